// File: rtl/mdu.sv
// Execute-stage multiply/divide unit holding the architectural HI/LO registers.
// The 64-bit result is computed at issue and published when the busy window closes.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        pend_wr_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi_q, pend_lo_q;

    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] dvd, dvs, dvs_nz, quo, rem, div_q, div_r;

    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'b0, A} * {32'b0, B};

        // Signed divide works on magnitudes; signs are restored afterwards, which also
        // makes 0x80000000 / -1 wrap to 0x80000000 with a zero remainder.
        div_signed = (op == OpDiv);
        dvd    = (div_signed && A[31]) ? -A : A;
        dvs    = (div_signed && B[31]) ? -B : B;
        dvs_nz = (dvs == 32'd0) ? 32'd1 : dvs;
        quo    = dvd / dvs_nz;
        rem    = dvd % dvs_nz;
        div_q  = (div_signed && (A[31] ^ B[31])) ? -quo : quo;
        div_r  = (div_signed && A[31]) ? -rem : rem;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        case (op)
                            OpMult, OpMultu: begin
                                {pend_hi_q, pend_lo_q} <= (op == OpMult) ? prod_s : prod_u;
                                pend_wr_q <= 1'b1;
                                cnt_q     <= 4'(MULT_CYCLES);
                                busy_q    <= 1'b1;
                                state_q   <= StRun;
                            end
                            OpDiv, OpDivu: begin
                                pend_hi_q <= div_r;
                                pend_lo_q <= div_q;
                                // Divide by zero still occupies the unit but leaves HI/LO alone
                                pend_wr_q <= (B != 32'd0);
                                cnt_q     <= 4'(DIV_CYCLES);
                                busy_q    <= 1'b1;
                                state_q   <= StRun;
                            end
                            OpMthi:  hi_q <= A;
                            OpMtlo:  lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    if (cnt_q == 4'd1) begin
                        if (pend_wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign stall_req = start | busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a timeline model of the unit is compared every cycle,
// and hand-computed HI/LO/busy-length values pin each scenario.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] A     = 32'd0;
    logic [31:0] B     = 32'd0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted operation finishes at a known edge number; results come from
    // plain 64-bit arithmetic on the operands.
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    bit          m_act = 0, m_wr = 0, m_was = 0;
    int          m_n = 0, m_done = 0;
    longint      sa, sb, sp;
    longint unsigned ua, ub, up;

    task automatic model_accept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (o)
            3'd0: begin sp = sa * sb; {m_phi, m_plo} = sp; m_wr = 1; m_done = m_n + MC; m_act = 1; end
            3'd1: begin up = ua * ub; {m_phi, m_plo} = up; m_wr = 1; m_done = m_n + MC; m_act = 1; end
            3'd2: begin
                m_wr = (b != 0);
                if (m_wr) begin m_plo = 32'(sa / sb); m_phi = 32'(sa % sb); end
                m_done = m_n + DC; m_act = 1;
            end
            3'd3: begin
                m_wr = (b != 0);
                if (m_wr) begin m_plo = 32'(ua / ub); m_phi = 32'(ua % ub); end
                m_done = m_n + DC; m_act = 1;
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = 0; m_lo = 0; m_act = 0; m_wr = 0;
        end else begin
            m_was = m_act;
            m_n++;
            if (m_was && m_n == m_done) begin
                if (m_wr) begin m_hi = m_phi; m_lo = m_plo; end
                m_act = 0;
            end else if (!m_was && start) begin
                model_accept(op, A, B);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("busy", {31'b0, busy}, {31'b0, m_act});
            chk("stall_req", {31'b0, stall_req}, {31'b0, start | m_act});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // Inputs change 1 time unit after the call, always away from both clock edges.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        #1;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input logic [31:0] eh,
                          input logic [31:0] el);
        int cnt;
        issue(o, a, b);
        wait_idle(cnt);
        chk({name, "_cycles"}, 32'(cnt), 32'(cyc));
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    int n;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);

        // Asynchronous reset while a multiply is in flight, with HI nonzero
        issue(3'd4, 32'h123, 32'h0);
        @(negedge clk);
        chk("mthi_pre", hi, 32'h123);
        issue(3'd0, 32'd5, 32'd7);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_hi", hi, 32'h0);
        chk("async_rst_lo", lo, 32'h0);
        chk("async_rst_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'h3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'h2, MC, 32'h1, 32'hFFFF_FFFE);
        run_op("div", 3'd2, 32'hFFFF_FFF9, 32'h2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h0, 32'h8000_0000);
        run_op("divu", 3'd3, 32'd100, 32'd7, DC, 32'd2, 32'd14);

        issue(3'd4, 32'h11, 32'h0);
        issue(3'd5, 32'h22, 32'h0);
        issue(3'd7, 32'hDEAD, 32'h0);
        @(negedge clk);
        chk("mt_hi", hi, 32'h11);
        chk("mt_lo", lo, 32'h22);
        run_op("div0", 3'd3, 32'd7, 32'd0, DC, 32'h11, 32'h22);

        // MTLO during busy is dropped; MTHI in the first idle cycle is taken
        issue(3'd0, 32'd3, 32'd4);
        issue(3'd5, 32'h55, 32'h0);
        wait_idle(n);
        chk("busy_ign_cycles", 32'(n), 32'(MC - 1));
        chk("busy_ign_lo", lo, 32'hC);
        chk("busy_ign_hi", hi, 32'h0);
        issue(3'd4, 32'hAB, 32'h0);
        @(negedge clk);
        chk("b2b_hi", hi, 32'hAB);
        chk("b2b_busy", {31'b0, busy}, 32'h0);

        // Start coinciding with the completion edge is ignored
        issue(3'd0, 32'd1, 32'd1);
        repeat (4) @(posedge clk);
        issue(3'd5, 32'h99, 32'h0);
        @(negedge clk);
        chk("cmpl_edge_lo", lo, 32'h1);
        chk("cmpl_edge_hi", hi, 32'h0);
        chk("cmpl_edge_busy", {31'b0, busy}, 32'h0);

        // Reset mid-divide (counter at 6), then a fresh multiply
        issue(3'd4, 32'h77, 32'h0);
        issue(3'd2, 32'd100, 32'd3);
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_hi", hi, 32'h0);
        chk("mid_rst_lo", lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        run_op("post_rst", 3'd0, 32'd2, 32'd2, MC, 32'h0, 32'h4);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Execute-stage multiply/divide unit. Sits beside the ALU and takes the same operand pair A/B from the ID/EX register.
- Holds the architectural HI/LO registers. The EX result mux selects hi/lo (for MFHI/MFLO) alongside the ALU result before EX/MEM.
- Multi-cycle: busy is driven to the hazard unit, which stalls any later MD-class instruction while an operation runs.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  issue strobe, one cycle per MD instruction in EX
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- A  input  32  rs operand (multiplicand/dividend; MTHI/MTLO source)
- B  input  32  rt operand (multiplier/divisor)
- busy  output  1  operation in progress
- stall_req  output  1  combinational start | busy, to the hazard unit
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: on reset high, immediately and asynchronously set hi=0, lo=0, busy=0, counter=0, state=IDLE, pending result=0. Reset mid-operation aborts the operation and leaves HI/LO at 0.
- States: IDLE, RUN.
- IDLE, start=1, op in MULT/MULTU/DIV/DIVU:
  - Latch the 64-bit result into pending_hi/pending_lo, computed from A/B at that edge.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1 and go to RUN.
  - busy is first high in the cycle after start.
- RUN: decrement counter each cycle. When counter reaches 1, on that edge:
  - hi<=pending_hi, lo<=pending_lo
  - busy<=0, go to IDLE
  - So busy is high exactly N cycles and the new HI/LO are visible the cycle busy falls.
- MULT: signed 32x32 to 64-bit product; hi=product[63:32], lo=product[31:0].
- MULTU: the same operation, unsigned.
- DIV: signed. lo=quotient truncated toward zero; hi=remainder, with the sign of the dividend.
- DIV special case: A=0x80000000, B=0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned; lo=quotient, hi=remainder.
- Divide by zero (B=0, DIV or DIVU): still busy for DIV_CYCLES; HI/LO are left unchanged at completion.
- MTHI/MTLO: in IDLE with start=1, hi<=A (or lo<=A) at that edge. No busy, single cycle.
- start with an undefined op: no effect.
- start while busy=1: ignored entirely. HI/LO, counter and pending values are unaffected. The hazard unit must not issue it; the bench checks that it is ignored.
- start on the same edge that a RUN operation completes: busy is still 1 on that edge, so the start is ignored.
- Back-to-back: start in the first IDLE cycle after completion is accepted normally.
- stall_req is purely combinational. It is high during the start cycle and for every busy cycle.
- hi/lo change only on the completion edge, on an MTHI/MTLO edge, or on reset. No intermediate values are ever visible.

Test Plan:
- Reset check: assert reset asynchronously mid-cycle -> hi=0, lo=0, busy=0 immediately, before the next clk edge.
- Signed multiply: MULT A=0xFFFFFFFE (-2), B=0x00000003 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned multiply: MULTU A=0xFFFFFFFF, B=0x00000002 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV special case: DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU A=7, B=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, then hi/lo still 0x11/0x22.
- Busy and move handling:
  - MULT 3*4, then MTLO A=0x55 issued during busy -> MTLO ignored; final lo=0x0000000C.
  - Next cycle after busy falls, MTHI A=0xAB -> hi=0xAB one cycle later, busy stays 0.
- Mid-operation reset: DIV running at counter=6, assert reset -> busy=0, hi=lo=0. A new MULT 2*2 then completes normally with lo=4.
